// File: rtl/multiplicador.sv
// Sequential shift-add unsigned multiplier.
// A start in IDLE latches the operands; N CALC steps later the 2N-bit
// product is written to produto and done1 pulses for one cycle.
module multiplicador #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           St,
  input  logic [N-1:0]   mndo,
  input  logic [N-1:0]   mdor,
  output logic           done1,
  output logic [2*N-1:0] produto
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   m_q, m_d;
  logic [2*N:0]   acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] prod_q, prod_d;
  logic           done_q, done_d;

  // One shift-add step. The upper part is N+1 bits wide so the carry of
  // the add lands in acc[2N] and survives the right shift.
  logic           last_step;
  logic [N:0]     addend;
  logic [N:0]     sum;
  logic [2*N:0]   pre_shift;
  logic [2*N:0]   stepped;

  assign last_step = (cnt_q == LAST);
  assign addend    = acc_q[0] ? {1'b0, m_q} : '0;
  assign sum       = acc_q[2*N:N] + addend;
  assign pre_shift = {sum, acc_q[N-1:0]};
  assign stepped   = pre_shift >> 1;

  assign done1   = done_q;
  assign produto = prod_q;

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start from IDLE, leave CALC after the N-th step.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (St) state_d = CALC;
      CALC: if (last_step) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values for the current state.
  always_comb begin
    m_d    = m_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    prod_d = prod_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (St) begin
          m_d   = mndo;
          acc_d = {{(N + 1){1'b0}}, mdor};
          cnt_d = '0;
        end
      end
      CALC: begin
        acc_d = stepped;
        cnt_d = cnt_q + CW'(1);
        if (last_step) begin
          prod_d = stepped[2*N-1:0];
          done_d = 1'b1;
        end
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  // Datapath and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      prod_q <= '0;
      done_q <= 1'b0;
    end else begin
      m_q    <= m_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      prod_q <= prod_d;
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_multiplicador.sv
// Self-checking bench for multiplicador: directed corner cases, randomized
// operands, back-to-back starts, ignored inputs during CALC and aborts.
module tb_multiplicador;

  localparam int N  = 4;
  localparam int PW = 2 * N;

  logic          clk;
  logic          rst;
  logic          St;
  logic [N-1:0]  mndo;
  logic [N-1:0]  mdor;
  logic          done1;
  logic [PW-1:0] produto;

  int checks;
  int errors;
  logic [PW-1:0] exp_prod;   // model: product of the last completed op

  multiplicador #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .St      (St),
    .mndo    (mndo),
    .mdor    (mdor),
    .done1   (done1),
    .produto (produto)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PW-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    int p;
    p = int'(a) * int'(b);
    return PW'(p);
  endfunction

  // One operation: St high for one edge, then watch N+2 edges.
  // With noisy set, St and the operands wiggle during CALC.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input bit noisy, input string tag);
    int pulses;
    logic [PW-1:0] want;
    want = ref_mul(a, b);
    pulses = 0;
    @(negedge clk);
    St = 1'b1; mndo = a; mdor = b;
    @(posedge clk);
    @(negedge clk);
    St = noisy ? 1'b1 : 1'b0;
    mndo = N'($urandom); mdor = N'($urandom);
    for (int i = 1; i <= N + 2; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (done1 !== (i == N)) begin
        errors++;
        $display("FAIL %s done1 edge k+%0d got %b want %b", tag, i, done1, (i == N));
      end
      if (done1 === 1'b1) pulses++;
      if (i < N) begin
        checks++;
        if (produto !== exp_prod) begin
          errors++;
          $display("FAIL %s produto early edge k+%0d got %0d want %0d", tag, i, produto, exp_prod);
        end
      end else begin
        checks++;
        if (produto !== want) begin
          errors++;
          $display("FAIL %s produto edge k+%0d got %0d want %0d", tag, i, produto, want);
        end
      end
      if (noisy) begin
        mndo = N'($urandom); mdor = N'($urandom);
        St = (i < N - 1);
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL %s pulse_count got %0d want 1", tag, pulses);
    end
    exp_prod = want;
    $display("op %s %0d x %0d -> produto %0d (want %0d)", tag, a, b, produto, want);
  endtask

  task automatic test_reset();
    rst = 1'b0; St = 1'b0; mndo = '0; mdor = '0;
    exp_prod = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (done1 !== 1'b0 || produto !== '0) begin
      errors++;
      $display("FAIL reset_state got done1=%b produto=%0d want 0/0", done1, produto);
    end
    @(negedge clk);
    rst = 1'b1;
    $display("reset released: done1=%b produto=%0d", done1, produto);
  endtask

  task automatic test_idle();
    int bad;
    bad = 0;
    St = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      mndo = N'($urandom); mdor = N'($urandom);
      @(posedge clk);
      #1;
      checks++;
      if (done1 !== 1'b0 || produto !== exp_prod) begin
        errors++; bad++;
        $display("FAIL idle cycle %0d got done1=%b produto=%0d want 0/%0d", i, done1, produto, exp_prod);
      end
    end
    $display("idle 20 cycles with St=0, %0d bad cycles", bad);
  endtask

  task automatic test_directed();
    run_op(4'd15, 4'd15, 1'b0, "max");
    run_op(4'd0,  4'd13, 1'b0, "zero_mndo");
    run_op(4'd1,  4'd15, 1'b0, "one_mndo");
    run_op(4'd15, 4'd1,  1'b0, "one_mdor");
    run_op(4'd10, 4'd12, 1'b0, "10x12");
    run_op(4'd13, 4'd0,  1'b0, "zero_mdor");
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      run_op(N'($urandom), N'($urandom), 1'b0, "rand");
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
  endtask

  task automatic test_ignore_inputs();
    // 15x15 running while St and operands move around (3x3 included).
    @(negedge clk);
    St = 1'b1; mndo = 4'd15; mdor = 4'd15;
    @(posedge clk);
    @(negedge clk);
    mndo = 4'd3; mdor = 4'd3;
    for (int i = 1; i <= N; i++) begin
      @(posedge clk);
      #1;
      if (i == N - 1) St = 1'b0;
    end
    checks++;
    if (done1 !== 1'b1 || produto !== 8'd225) begin
      errors++;
      $display("FAIL ignore_3x3 got done1=%b produto=%0d want 1/225", done1, produto);
    end
    exp_prod = 8'd225;
    $display("op ignore 15x15 with 3x3 during CALC -> produto %0d", produto);
    run_op(4'd3, 4'd3, 1'b0, "after_ignore");
    for (int t = 0; t < 10; t++) begin
      run_op(N'($urandom), N'($urandom), 1'b1, "noisy");
    end
  endtask

  // St held high: a start every N+1 edges, done1 on each k+N.
  task automatic back_to_back(input logic [N-1:0] a, input logic [N-1:0] b, input int ops);
    int pulses;
    int last;
    logic [PW-1:0] want;
    logic exp_done;
    want = ref_mul(a, b);
    pulses = 0;
    last = ops * (N + 1) - 1;
    @(negedge clk);
    St = 1'b1; mndo = a; mdor = b;
    @(posedge clk);
    for (int j = 1; j <= last; j++) begin
      @(posedge clk);
      #1;
      exp_done = ((j % (N + 1)) == N);
      checks++;
      if (done1 !== exp_done) begin
        errors++;
        $display("FAIL b2b done1 edge %0d got %b want %b", j, done1, exp_done);
      end
      if (done1 === 1'b1) pulses++;
      if (j >= N) begin
        checks++;
        if (produto !== want) begin
          errors++;
          $display("FAIL b2b produto edge %0d got %0d want %0d", j, produto, want);
        end
      end
      if (j == last) St = 1'b0;
    end
    exp_prod = want;
    repeat (2) begin
      @(posedge clk);
      #1;
      checks++;
      if (done1 !== 1'b0) begin
        errors++;
        $display("FAIL b2b trailing done1 got %b want 0", done1);
      end
    end
    checks++;
    if (pulses != ops) begin
      errors++;
      $display("FAIL b2b pulse_count got %0d want %0d", pulses, ops);
    end
    $display("b2b %0d x %0d held for %0d ops -> %0d pulses produto %0d", a, b, ops, pulses, produto);
  endtask

  task automatic test_back_to_back();
    back_to_back(4'd15, 4'd15, 4);
    back_to_back(N'($urandom), N'($urandom), 3);
  endtask

  task automatic test_abort();
    run_op(4'd9, 4'd7, 1'b0, "pre_abort");
    @(negedge clk);
    St = 1'b1; mndo = 4'd15; mdor = 4'd15;
    @(posedge clk);
    @(negedge clk);
    St = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (produto !== '0 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL abort_immediate got done1=%b produto=%0d want 0/0", done1, produto);
    end
    exp_prod = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < N + 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (done1 !== 1'b0 || produto !== '0) begin
        errors++;
        $display("FAIL abort_after cycle %0d got done1=%b produto=%0d want 0/0", i, done1, produto);
      end
    end
    $display("abort mid-CALC: produto %0d done1 %b", produto, done1);
    run_op(4'd5, 4'd6, 1'b0, "after_abort");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_idle();
    test_directed();
    test_random();
    test_ignore_inputs();
    test_back_to_back();
    test_abort();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
